// File: rtl/cost_rom_arb_if.sv
// Bus bundle between two cost-ROM requesters, the arbiter and the ROM.
// The master side drives requests and ROM data; the arbiter is the slave.
interface cost_rom_arb_if;
  logic       REQ0;
  logic       REQ1;
  logic [2:0] W0;
  logic [2:0] J0;
  logic [2:0] W1;
  logic [2:0] J1;
  logic       LAST0;
  logic       LAST1;
  logic       GNT0;
  logic       GNT1;
  logic [2:0] W;
  logic [2:0] J;
  logic [6:0] Cost;
  logic [6:0] RDATA;
  logic       RVLD0;
  logic       RVLD1;

  modport slave (
    input  REQ0, REQ1,
    input  W0, J0, W1, J1,
    input  LAST0, LAST1,
    input  Cost,
    output GNT0, GNT1,
    output W, J,
    output RDATA,
    output RVLD0, RVLD1
  );

  modport master (
    output REQ0, REQ1,
    output W0, J0, W1, J1,
    output LAST0, LAST1,
    output Cost,
    input  GNT0, GNT1,
    input  W, J,
    input  RDATA,
    input  RVLD0, RVLD1
  );
endinterface

// File: rtl/cost_rom_arb.sv
// Two-requester round-robin arbiter for a shared combinational cost ROM.
// Bursts end on LAST, a beat-count cap, or the owner dropping its request.
module cost_rom_arb #(
  parameter int MAX_BURST = 8
) (
  input logic           CLK,
  input logic           RST,
  cost_rom_arb_if.slave bus
);

  localparam logic [3:0] BC_LAST = 4'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } st_t;

  st_t        st;
  logic       pri;
  logic [3:0] bc;
  logic       gnt0_q;
  logic       gnt1_q;
  logic [6:0] rdata_q;
  logic       rv0_q;
  logic       rv1_q;

  logic idle;
  logic own0;
  logic own1;
  logic req_own;
  logic last_own;
  logic beat;
  logic bend;
  logic g0;
  logic g1;

  // Decode current owner, detect beats and burst ends, pick next owner.
  always_comb begin
    idle     = (st == IDLE);
    own0     = (st == OWN0);
    own1     = (st == OWN1);
    req_own  = (own0 & bus.REQ0) | (own1 & bus.REQ1);
    last_own = (own0 & bus.LAST0) | (own1 & bus.LAST1);
    beat     = req_own;
    bend     = (own0 | own1)
             & (~req_own | last_own | (bc == BC_LAST));
    g0 = 1'b0;
    g1 = 1'b0;
    unique case (1'b1)
      idle: begin
        g0 = bus.REQ0 & (~bus.REQ1 | ~pri);
        g1 = bus.REQ1 & (~bus.REQ0 | pri);
      end
      bend & own0: begin
        g1 = bus.REQ1;
        g0 = bus.REQ0 & ~bus.REQ1;
      end
      bend & own1: begin
        g0 = bus.REQ0;
        g1 = bus.REQ1 & ~bus.REQ0;
      end
      default: begin
        g0 = own0;
        g1 = own1;
      end
    endcase
  end

  // Route the owner's address to the ROM; park at zero when idle.
  always_comb begin
    bus.W = 3'd0;
    bus.J = 3'd0;
    unique case (1'b1)
      own0: begin
        bus.W = bus.W0;
        bus.J = bus.J0;
      end
      own1: begin
        bus.W = bus.W1;
        bus.J = bus.J1;
      end
      default: begin
        bus.W = 3'd0;
        bus.J = 3'd0;
      end
    endcase
  end

  // Ownership FSM with registered grants, priority and beat count.
  always_ff @(posedge CLK) begin
    if (RST) begin
      st     <= IDLE;
      pri    <= 1'b0;
      bc     <= 4'd0;
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
    end else begin
      gnt0_q <= g0;
      gnt1_q <= g1;
      if (g0) begin
        st <= OWN0;
      end else if (g1) begin
        st <= OWN1;
      end else begin
        st <= IDLE;
      end
      if (bend) begin
        pri <= own0;
      end
      if (idle | bend) begin
        bc <= 4'd0;
      end else if (beat) begin
        bc <= bc + 4'd1;
      end
    end
  end

  // Capture ROM data one cycle after each beat and tag its owner.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rdata_q <= 7'd0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
    end else begin
      rv0_q <= beat & own0;
      rv1_q <= beat & own1;
      if (beat) begin
        rdata_q <= bus.Cost;
      end
    end
  end

  assign bus.GNT0  = gnt0_q;
  assign bus.GNT1  = gnt1_q;
  assign bus.RDATA = rdata_q;
  assign bus.RVLD0 = rv0_q;
  assign bus.RVLD1 = rv1_q;

endmodule
